// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM state encoding, byte-enable helper,
// default timeout and the opcode/funct3 constants pulled from inst_defs.sv.
`include "inst_defs.sv"

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } lsu_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  localparam logic [6:0] OPC_LOAD  = `OP_LD;
  localparam logic [6:0] OPC_STORE = `OP_ST;
  localparam logic [2:0] F3_BYTE   = `F3_B;
  localparam logic [2:0] F3_HALF   = `F3_H;
  localparam logic [2:0] F3_WORD   = `F3_W;
  localparam logic [2:0] F3_BYTE_U = `F3_BU;
  localparam logic [2:0] F3_HALF_U = `F3_HU;

  // Access size lives in funct3[1:0]; bit 2 only selects zero-extension.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                             input logic [1:0] offset);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/inst_defs.sv
// Shared RV32I opcode and funct3 encodings used by the memory-stage blocks.
`ifndef INST_DEFS_SV
`define INST_DEFS_SV
`define OP_LD  7'b0000011
`define OP_ST  7'b0100011
`define F3_B   3'b000
`define F3_H   3'b001
`define F3_W   3'b010
`define F3_BU  3'b100
`define F3_HU  3'b101
`endif

// File: rtl/lsu_load_align.sv
// Load result formatting: shifts the read word down to the accessed lane and
// sign- or zero-extends according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       offset,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] load_data
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_BYTE:   load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_HALF:   load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_BYTE_U: load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      F3_HALF_U: load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory load/store initiator: one transaction at a time, with grant and
// read-data timeouts. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] load_data,
  output logic             misaligned,
  output logic             bus_error,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-3:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state, state_next;
  logic             timeout;

  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic [WIDTH-3:0] word_addr_q;
  logic [3:0]       be_q;
  logic [WIDTH-1:0] wdata_q;
  logic             we_q;
  logic [WIDTH-1:0] load_data_q;
  logic             misaligned_q;
  logic             bus_error_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] aligned_data;

  logic             is_ld, is_st, f3_ok, align_bad, req_misaligned, req_mem;
  logic [1:0]       req_off;

  // Classify the incoming request; illegal funct3 always reports misaligned.
  always_comb begin
    is_ld = (opcode == OPC_LOAD);
    is_st = (opcode == OPC_STORE);
    if (is_ld) begin
      f3_ok = funct3 inside {F3_BYTE, F3_HALF, F3_WORD, F3_BYTE_U, F3_HALF_U};
    end else begin
      f3_ok = funct3 inside {F3_BYTE, F3_HALF, F3_WORD};
    end
`ifdef LSU_MISALIGN_TRAP_EN
    req_off   = addr[1:0];
    align_bad = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    if (funct3[1:0] == 2'b10) begin
      req_off = 2'b00;
    end else if (funct3[1:0] == 2'b01) begin
      req_off = {addr[1], 1'b0};
    end else begin
      req_off = addr[1:0];
    end
    align_bad = 1'b0;
`endif
    req_misaligned = (is_ld || is_st) && (!f3_ok || align_bad);
    req_mem        = (is_ld || is_st) && !req_misaligned;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = req_mem ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_next = we_q ? RESP : WAIT_RD;
        end else if (wait_cnt == CNT_LIMIT) begin
          state_next = RESP;
          timeout    = 1'b1;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          state_next = RESP;
        end else if (wait_cnt == CNT_LIMIT) begin
          state_next = RESP;
          timeout    = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, wait counter and registered response fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct3_q     <= '0;
      off_q        <= '0;
      word_addr_q  <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        funct3_q     <= funct3;
        off_q        <= req_off;
        word_addr_q  <= addr[WIDTH-1:2];
        be_q         <= byte_enable(funct3, req_off);
        wdata_q      <= store_data << {req_off, 3'b000};
        we_q         <= is_st;
        load_data_q  <= '0;
        misaligned_q <= req_misaligned;
        bus_error_q  <= 1'b0;
      end
      if (state != state_next) begin
        wait_cnt <= '0;
      end else if (state == ISSUE || state == WAIT_RD) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (state == WAIT_RD && mem_rvalid) begin
        load_data_q <= aligned_data;
      end
      if (timeout) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  lsu_load_align #(
    .WIDTH (WIDTH)
  ) u_load_align (
    .funct3    (funct3_q),
    .offset    (off_q),
    .rdata     (mem_rdata),
    .load_data (aligned_data)
  );

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign mem_req    = (state == ISSUE);
  assign mem_we     = we_q;
  assign mem_addr   = word_addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign bus_error  = bus_error_q;

endmodule
